// File: rtl/gen_regfile_mp_pkg.sv
// Shared configuration for the multi-port register file.
// REGFILE_BYPASS_EN selects write-first read collisions; undefined gives read-first.
package gen_regfile_mp_pkg;

    localparam int   XLEN_DEFAULT = 32;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

`ifdef REGFILE_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/gen_regfile_mp_read_port.sv
// One registered read port: address mux, optional write bypass, hold-on-disable outputs.
// Write-first forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import gen_regfile_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NSLOT = 32,
    parameter int NWR   = 1,
    parameter int AW    = $clog2(NSLOT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_flag,
    input  logic [AW-1:0]        rd_addr,
    input  logic [XLEN-1:0]      regs [NSLOT],
    input  logic [NSLOT-1:0]     busy,
    input  logic [NWR-1:0]       wr_flag,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 alloc_flag,
    input  logic [AW-1:0]        alloc_addr,
    output logic [XLEN-1:0]      rd_data,
    output logic                 rd_busy
);

    logic [XLEN-1:0] data_p0;
    logic            busy_p0;

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_flag, wr_addr, wr_data, alloc_flag, alloc_addr};
`endif

    // Stage p0: select register state, forwarding a coincident write when enabled
    always_comb begin
        data_p0 = '0;
        busy_p0 = 1'b0;
        if (rd_addr != '0) begin
            data_p0 = regs[rd_addr];
            busy_p0 = busy[rd_addr];
        end
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NWR; k++) begin
            if (WRITE_ENABLE && wr_flag[k] && rd_addr != '0 &&
                wr_addr[k*AW +: AW] == rd_addr) begin
                data_p0 = wr_data[k*XLEN +: XLEN];
                busy_p0 = alloc_flag && (alloc_addr == rd_addr);
            end
        end
`endif
    end

    // Stage p1: output registers, held while the port is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (READ_ENABLE && rd_flag) begin
            rd_data <= data_p0;
            rd_busy <= busy_p0;
        end
    end

endmodule

// File: rtl/gen_regfile_mp.sv
// Parametrised multi-port integer register file with per-register busy scoreboard.
// Build option REGFILE_BYPASS_EN makes same-cycle reads return the data being written.
module gen_regfile_mp
    import gen_regfile_mp_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWR-1:0]       i_write_flag,
    input  logic [NWR*AW-1:0]    i_write_addr,
    input  logic [NWR*XLEN-1:0]  i_write_data,
    input  logic [NRD-1:0]       i_read_flag,
    input  logic [NRD*AW-1:0]    i_read_addr,
    output logic [NRD*XLEN-1:0]  o_read_data,
    output logic [NRD-1:0]       o_read_busy,
    input  logic                 i_alloc_flag,
    input  logic [AW-1:0]        i_alloc_addr
);

    // Storage is padded to the full address space so every read index is in range
    localparam int NSLOT = 1 << AW;

    logic [XLEN-1:0]  regs [NSLOT];
    logic [NSLOT-1:0] busy;

    // Later write ports override earlier ones; alloc is applied last so it beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
            busy <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (WRITE_ENABLE && i_write_flag[k] && i_write_addr[k*AW +: AW] != '0) begin
                    regs[i_write_addr[k*AW +: AW]] <= i_write_data[k*XLEN +: XLEN];
                    busy[i_write_addr[k*AW +: AW]] <= 1'b0;
                end
            end
            if (i_alloc_flag && i_alloc_addr != '0)
                busy[i_alloc_addr] <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    if (NSLOT != NREG) begin : g_addr_chk
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k < NWR; k++)
                    assert (!(i_write_flag[k] && i_write_addr[k*AW +: AW] >= AW'(NREG)))
                        else $error("write port %0d addresses nonexistent register", k);
            end
        end
    end
`endif

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        regfile_read_port #(
            .XLEN  (XLEN),
            .NSLOT (NSLOT),
            .NWR   (NWR),
            .AW    (AW)
        ) u_rp (
            .clk        (clk),
            .rst        (rst),
            .rd_flag    (i_read_flag[j]),
            .rd_addr    (i_read_addr[j*AW +: AW]),
            .regs       (regs),
            .busy       (busy),
            .wr_flag    (i_write_flag),
            .wr_addr    (i_write_addr),
            .wr_data    (i_write_data),
            .alloc_flag (i_alloc_flag),
            .alloc_addr (i_alloc_addr),
            .rd_data    (o_read_data[j*XLEN +: XLEN]),
            .rd_busy    (o_read_busy[j])
        );
    end

endmodule

// File: tb/tb_gen_regfile_mp.sv
// Scoreboard bench for gen_regfile_mp (NRD=2, NWR=2); collision expectations follow REGFILE_BYPASS_EN.
module tb_gen_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      i_write_flag;
    logic [NWR*AW-1:0]   i_write_addr;
    logic [NWR*XLEN-1:0] i_write_data;
    logic [NRD-1:0]      i_read_flag;
    logic [NRD*AW-1:0]   i_read_addr;
    logic [NRD*XLEN-1:0] o_read_data;
    logic [NRD-1:0]      o_read_busy;
    logic                i_alloc_flag;
    logic [AW-1:0]       i_alloc_addr;

    gen_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_write_flag (i_write_flag),
        .i_write_addr (i_write_addr),
        .i_write_data (i_write_data),
        .i_read_flag  (i_read_flag),
        .i_read_addr  (i_read_addr),
        .o_read_data  (o_read_data),
        .o_read_busy  (o_read_busy),
        .i_alloc_flag (i_alloc_flag),
        .i_alloc_addr (i_alloc_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [31:0] act_d, logic [31:0] exp_d,
                         logic act_b, logic exp_b);
        total++;
        if (act_d !== exp_d || act_b !== exp_b) begin
            bad++;
            $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                     name, act_d, act_b, exp_d, exp_b);
        end
    endtask

    // Monitor: compare every expectation due after the current rising edge
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: expectation missed (due %0d, now %0d)", e.name, e.due, cyc);
            end else begin
                check(e.name, o_read_data[e.port*XLEN +: XLEN], e.data,
                      o_read_busy[e.port], e.busy);
            end
        end
    end

    task automatic clr();
        i_write_flag = '0;
        i_read_flag  = '0;
        i_alloc_flag = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(int p, int a, logic [31:0] d);
        i_write_flag[p]           = 1'b1;
        i_write_addr[p*AW +: AW]  = AW'(a);
        i_write_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(int p, int a, logic [31:0] ed, logic eb, string n);
        exp_t e;
        i_read_flag[p]          = 1'b1;
        i_read_addr[p*AW +: AW] = AW'(a);
        e.due = cyc + 1; e.port = p; e.data = ed; e.busy = eb; e.name = n;
        q.push_back(e);
    endtask

    task automatic expect_hold(int p, int a, logic [31:0] ed, logic eb, string n);
        exp_t e;
        i_read_addr[p*AW +: AW] = AW'(a);
        e.due = cyc + 1; e.port = p; e.data = ed; e.busy = eb; e.name = n;
        q.push_back(e);
    endtask

    task automatic alloc(int a);
        i_alloc_flag = 1'b1;
        i_alloc_addr = AW'(a);
    endtask

    logic [31:0] coll_exp;

    initial begin
        rst = 1'b1;
        i_write_addr = '0; i_write_data = '0; i_read_addr = '0; i_alloc_addr = '0;
        clr();
        tick();
        check("reset_init_p0", o_read_data[0 +: XLEN], 32'h0, o_read_busy[0], 1'b0);
        check("reset_init_p1", o_read_data[XLEN +: XLEN], 32'h0, o_read_busy[1], 1'b0);
        tick();
        rst = 1'b0;

        // Basic write then read on two ports
        clr(); wr(0, 5, 32'hDEADBEEF); tick();
        clr(); rd(0, 5, 32'hDEADBEEF, 1'b0, "read_x5"); rd(1, 0, 32'h0, 1'b0, "read_x0"); tick();

        // Hold port 0 while its address changes
        for (int i = 0; i < 3; i++) begin
            clr(); expect_hold(0, 6 + i, 32'hDEADBEEF, 1'b0, "hold_p0"); tick();
        end

        // Writes to x0 are dropped
        clr(); wr(0, 0, 32'h1234); tick();
        clr(); rd(1, 0, 32'h0, 1'b0, "x0_after_write"); tick();

        // Same-cycle write/read collision
`ifdef REGFILE_BYPASS_EN
        coll_exp = 32'hA5A5A5A5;
`else
        coll_exp = 32'h0;
`endif
        clr(); wr(0, 7, 32'hA5A5A5A5); rd(0, 7, coll_exp, 1'b0, "collision_x7"); tick();
        clr(); rd(0, 7, 32'hA5A5A5A5, 1'b0, "after_collision_x7"); tick();

        // Dual write to one address: port 1 wins
        clr(); wr(0, 9, 32'h1); wr(1, 9, 32'h2); tick();
        clr(); rd(1, 9, 32'h2, 1'b0, "dual_write_x9"); tick();

        // Scoreboard: alloc, alloc+write, write alone
        clr(); alloc(3); tick();
        clr(); rd(0, 3, 32'h0, 1'b1, "busy_after_alloc"); tick();
        clr(); wr(1, 3, 32'h33); alloc(3); tick();
        clr(); rd(0, 3, 32'h33, 1'b1, "busy_alloc_and_write"); tick();
        clr(); wr(0, 3, 32'h44); tick();
        clr(); rd(0, 3, 32'h44, 1'b0, "busy_cleared"); tick();

        // Alloc to x0 is dropped; x2 alloc becomes visible
        clr(); alloc(0); tick();
        clr(); alloc(2); rd(1, 0, 32'h0, 1'b0, "x0_alloc_dropped"); tick();
        clr(); rd(1, 2, 32'h0, 1'b1, "busy_x2"); tick();

        // Asynchronous reset with nonzero outputs
        clr(); rd(0, 5, 32'hDEADBEEF, 1'b0, "pre_reset_p0"); rd(1, 3, 32'h44, 1'b0, "pre_reset_p1");
        alloc(4); tick();
        clr();
        #2 rst = 1'b1;
        #1;
        check("async_reset_p0", o_read_data[0 +: XLEN], 32'h0, o_read_busy[0], 1'b0);
        check("async_reset_p1", o_read_data[XLEN +: XLEN], 32'h0, o_read_busy[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Everything cleared, including busy bits
        for (int a = 1; a < NREG; a++) begin
            clr(); rd(a % 2, a, 32'h0, 1'b0, "post_reset_zero"); tick();
        end

        clr(); tick(); tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
